// File: rtl/tone_decoder.sv
// Measures the period of a square-wave tone and decodes it to one of seven scale notes C4..B4.
// Outputs are registered one clk after the edge-detect cycle; there is no backpressure and the decoder always samples.
module tone_decoder #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int CNT_W       = 22,
    parameter int TIMEOUT_CYC = 2_000_000,
    parameter int STABLE_N    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tone_in,
    output logic       note_valid,
    output logic [2:0] note_idx,
    output logic       note_strobe,
    output logic [6:0] lamp_data
);
    localparam int SW = $clog2(STABLE_N + 1);
    localparam int unsigned NOM [7] = '{CLK_HZ / 262, CLK_HZ / 294, CLK_HZ / 330, CLK_HZ / 349,
                                        CLK_HZ / 392, CLK_HZ / 440, CLK_HZ / 494};

    typedef enum logic [1:0] {SILENT, ACQUIRE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic            s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      cand_q, cand_d;
    logic [SW-1:0]   match_q, match_d;
    logic [SW-1:0]   miss_q, miss_d;
    logic [2:0]      note_q, note_d;
    logic            valid_q, valid_d;
    logic            strobe_q, strobe_d;
    logic [6:0]      lamp_q, lamp_d;
    logic            edge_det;
    logic            timeout;
    logic [2:0]      cls;

    // Scan from the highest note down so the lowest matching index wins on overlap.
    function automatic logic [2:0] classify(input logic [CNT_W-1:0] p);
        int unsigned pw;
        logic [2:0]  c;
        pw = 32'(p);
        c  = 3'd0;
        for (int k = 6; k >= 0; k--) begin
            if (pw >= NOM[k] - (NOM[k] >> 5) && pw <= NOM[k] + (NOM[k] >> 5)) begin
                c = 3'(k + 1);
            end
        end
        return c;
    endfunction

    assign edge_det = s2_q & ~s3_q;
    assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYC)) && !edge_det;
    assign cls      = classify(cnt_q);

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        match_d  = match_q;
        miss_d   = miss_q;
        note_d   = note_q;
        valid_d  = valid_q;
        strobe_d = 1'b0;

        if (edge_det) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            SILENT: begin
                if (edge_det) begin
                    state_d = ACQUIRE;
                    cand_d  = 3'd0;
                    match_d = '0;
                    miss_d  = '0;
                end
            end
            ACQUIRE, LOCKED: begin
                if (edge_det) begin
                    if (state_q == LOCKED && cls == note_q) begin
                        cand_d  = 3'd0;
                        match_d = '0;
                        miss_d  = '0;
                    end else if (cls != 3'd0) begin
                        if (cls == cand_q) begin
                            match_d = match_q + SW'(1);
                        end else begin
                            cand_d  = cls;
                            match_d = SW'(1);
                        end
                        if (match_d == SW'(STABLE_N)) begin
                            if (state_q == ACQUIRE) begin
                                miss_d = '0;
                            end
                            state_d  = LOCKED;
                            note_d   = cand_d;
                            valid_d  = 1'b1;
                            strobe_d = 1'b1;
                            cand_d   = 3'd0;
                            match_d  = '0;
                        end
                    end else begin
                        cand_d  = 3'd0;
                        match_d = '0;
                        if (state_q == LOCKED) begin
                            miss_d = miss_q + SW'(1);
                            if (miss_d == SW'(STABLE_N)) begin
                                state_d = ACQUIRE;
                                note_d  = 3'd0;
                                valid_d = 1'b0;
                                miss_d  = '0;
                            end
                        end
                    end
                end
            end
            default: state_d = SILENT;
        endcase

        // Silence overrides everything except a coincident edge.
        if (timeout) begin
            state_d  = SILENT;
            cand_d   = 3'd0;
            match_d  = '0;
            miss_d   = '0;
            note_d   = 3'd0;
            valid_d  = 1'b0;
            strobe_d = 1'b0;
        end

        lamp_d = (note_d == 3'd0) ? 7'd0 : (7'd1 << (note_d - 3'd1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SILENT;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            cnt_q    <= '0;
            cand_q   <= 3'd0;
            match_q  <= '0;
            miss_q   <= '0;
            note_q   <= 3'd0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            lamp_q   <= 7'd0;
        end else begin
            state_q  <= state_d;
            s1_q     <= tone_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            note_q   <= note_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            lamp_q   <= lamp_d;
        end
    end

    assign note_valid  = valid_q;
    assign note_idx    = note_q;
    assign note_strobe = strobe_q;
    assign lamp_data   = lamp_q;
endmodule

// File: tb/tb_tone_decoder.sv
// Randomized and directed tone stimulus against a period-list reference model with a queued scoreboard.
module tb_tone_decoder;
    localparam int CLK_HZ = 100_000;
    localparam int T      = 1000;
    localparam int S      = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tone_in = 1'b0;
    logic       note_valid;
    logic [2:0] note_idx;
    logic       note_strobe;
    logic [6:0] lamp_data;

    tone_decoder #(.CLK_HZ(CLK_HZ), .CNT_W(22), .TIMEOUT_CYC(T), .STABLE_N(S)) dut (
        .clk(clk), .rst(rst), .tone_in(tone_in), .note_valid(note_valid),
        .note_idx(note_idx), .note_strobe(note_strobe), .lamp_data(lamp_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       v;
        logic [2:0] idx;
        logic       st;
    } exp_t;
    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;

    int unsigned freq [7] = '{262, 294, 330, 349, 392, 440, 494};

    // Reference model: 0 silent, 1 acquiring, 2 locked.
    int m_state = 0;
    int m_last  = 0;
    bit m_has   = 0;
    int m_cand  = 0;
    int m_mc    = 0;
    int m_miss  = 0;
    int m_note  = 0;

    function automatic int nominal(int k);
        return CLK_HZ / int'(freq[k - 1]);
    endfunction

    function automatic int ref_class(int p);
        for (int k = 1; k <= 7; k++) begin
            int n, d;
            n = nominal(k);
            d = (p > n) ? p - n : n - p;
            if (d <= (n >> 5)) return k;
        end
        return 0;
    endfunction

    function automatic logic [6:0] lamp_of(logic [2:0] idx);
        logic [6:0] l;
        l = 7'd0;
        if (idx != 3'd0) l[idx - 3'd1] = 1'b1;
        return l;
    endfunction

    task automatic push(int c, int v, int idx);
        exp_t e;
        e.cyc = c;
        e.v   = 1'(v);
        e.idx = 3'(idx);
        e.st  = 1'(v);
        exp_q.push_back(e);
    endtask

    task automatic model_tick(int c);
        if (m_state != 0 && m_has && (c - m_last) > T) begin
            if (m_note != 0) push(m_last + T + 3, 0, 0);
            m_state = 0; m_note = 0; m_cand = 0; m_mc = 0; m_miss = 0;
        end
    endtask

    task automatic model_reset(int c);
        if (m_note != 0) push(c, 0, 0);
        m_state = 0; m_note = 0; m_cand = 0; m_mc = 0; m_miss = 0; m_has = 0;
    endtask

    task automatic model_rise(int c);
        int k;
        if (m_state == 0) begin
            m_state = 1; m_cand = 0; m_mc = 0; m_miss = 0;
            m_last = c; m_has = 1;
            return;
        end
        k = ref_class(c - m_last);
        m_last = c;
        if (m_state == 2 && k == m_note) begin
            m_cand = 0; m_mc = 0; m_miss = 0;
        end else if (k != 0) begin
            if (k == m_cand) m_mc++;
            else begin m_cand = k; m_mc = 1; end
            if (m_mc == S) begin
                if (m_state == 1) m_miss = 0;
                m_state = 2; m_note = m_cand;
                push(c + 3, 1, m_note);
                m_cand = 0; m_mc = 0;
            end
        end else begin
            m_cand = 0; m_mc = 0;
            if (m_state == 2) begin
                m_miss++;
                if (m_miss == S) begin
                    m_state = 1; m_note = 0; m_miss = 0;
                    push(c + 3, 0, 0);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_tick(cyc);
    endtask

    task automatic seg(int p, int n);
        for (int i = 0; i < n; i++) begin
            step();
            tone_in = 1'b1;
            model_rise(cyc);
            for (int j = 1; j < p; j++) begin
                step();
                if (j == p / 2) tone_in = 1'b0;
            end
        end
    endtask

    task automatic quiet(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        model_reset(cyc + 1);
        step();
        tone_in = ~tone_in;
        step();
        tone_in = 1'b0;
        rst = 1'b0;
        quiet(5);
    endtask

    logic       mon_en = 1'b0;
    logic       pv = 1'b0;
    logic [2:0] pi = 3'd0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (note_valid !== pv || note_idx !== pi) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_change cyc=%0d got v=%0b idx=%0d st=%0b, none expected",
                             cyc, note_valid, note_idx, note_strobe);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.v !== note_valid || e.idx !== note_idx ||
                        e.st !== note_strobe || lamp_data !== lamp_of(e.idx)) begin
                        fails++;
                        $display("FAIL note_event got cyc=%0d v=%0b idx=%0d st=%0b lamp=%b, want cyc=%0d v=%0b idx=%0d st=%0b lamp=%b",
                                 cyc, note_valid, note_idx, note_strobe, lamp_data,
                                 e.cyc, e.v, e.idx, e.st, lamp_of(e.idx));
                    end
                end
            end else if (note_strobe !== 1'b0) begin
                tests++;
                fails++;
                $display("FAIL stray_strobe cyc=%0d got st=%0b idx=%0d, want st=0", cyc, note_strobe, note_idx);
            end
            pv = note_valid;
            pi = note_idx;
        end
    end

    initial begin
        do_reset();
        tests++;
        if (note_valid !== 1'b0 || note_idx !== 3'd0 || note_strobe !== 1'b0 || lamp_data !== 7'd0) begin
            fails++;
            $display("FAIL reset_state got v=%0b idx=%0d st=%0b lamp=%b, want all 0",
                     note_valid, note_idx, note_strobe, lamp_data);
        end
        mon_en = 1'b1;

        // Lock on A4, change to B4, detune out, window edges.
        seg(nominal(6), 5);
        seg(nominal(7), 4);
        seg(nominal(6), 4);
        seg(nominal(6) + 13, 4);
        seg(nominal(6) + (nominal(6) >> 5), 4);
        seg(nominal(6) + (nominal(6) >> 5) + 1, 4);
        seg(nominal(6) - (nominal(6) >> 5), 4);

        // Silence drop and relock.
        quiet(T + 100);
        seg(nominal(6), 5);

        // Reset while locked on C4, then relock.
        seg(nominal(1), 5);
        do_reset();
        seg(nominal(1), 5);

        for (int s = 0; s < 20; s++) begin
            int mode, k, n, w;
            mode = int'($urandom_range(0, 9));
            if (mode <= 5) begin
                k = int'($urandom_range(1, 7));
                n = nominal(k);
                w = n >> 5;
                seg(n - w + int'($urandom_range(0, 2 * w)), int'($urandom_range(1, 5)));
            end else if (mode <= 7) begin
                seg(int'($urandom_range(150, 450)), int'($urandom_range(1, 5)));
            end else if (mode == 8) begin
                seg(int'($urandom_range(2, 6)), int'($urandom_range(1, 3)));
            end else begin
                quiet(int'($urandom_range(T - 100, T + 200)));
            end
        end

        quiet(T + 50);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending events, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
